// File: rtl/param_exec_datapath.sv
// Execute datapath: register file, barrel shifter, ALU with NZCV flags and a PC,
// sequenced IDLE -> READ -> EXEC -> WRITE behind a single-issue request/done handshake.
module param_exec_datapath #(
    parameter int  DATA_W  = 32,
    parameter int  NREGS   = 16,
    parameter int  PC_STEP = 4,
    localparam int ADDR_W  = $clog2(NREGS),
    localparam int SHAMT_W = $clog2(DATA_W)
) (
    input  logic               Clk,
    input  logic               RESET,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [3:0]         op,
    input  logic               s_bit,
    input  logic [ADDR_W-1:0]  rn,
    input  logic [ADDR_W-1:0]  rm,
    input  logic [ADDR_W-1:0]  rs,
    input  logic [ADDR_W-1:0]  rd,
    input  logic [1:0]         shift_type,
    input  logic               shift_by_reg,
    input  logic [SHAMT_W-1:0] shift_imm,
    input  logic               pc_load,
    input  logic [DATA_W-1:0]  pc_in,
    input  logic               pc_inc,
    output logic [DATA_W-1:0]  result,
    output logic [3:0]         flags,
    output logic               done,
    output logic [DATA_W-1:0]  pc_out,
    input  logic [ADDR_W-1:0]  dbg_rsel,
    output logic [DATA_W-1:0]  dbg_rdata
);

    localparam logic [3:0] OP_AND = 4'd0,  OP_EOR = 4'd1,  OP_SUB = 4'd2,  OP_RSB = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4,  OP_ADC = 4'd5,  OP_SBC = 4'd6,  OP_RSC = 4'd7;
    localparam logic [3:0] OP_TST = 4'd8,  OP_TEQ = 4'd9,  OP_CMP = 4'd10, OP_CMN = 4'd11;
    localparam logic [3:0] OP_ORR = 4'd12, OP_MOV = 4'd13, OP_BIC = 4'd14, OP_MVN = 4'd15;
    localparam logic [SHAMT_W:0] DATA_W_L = (SHAMT_W + 1)'(DATA_W);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;
    state_t state_reg, state_next;

    logic [3:0]         op_reg;
    logic               s_bit_reg, shift_by_reg_reg;
    logic [ADDR_W-1:0]  rn_reg, rm_reg, rs_reg, rd_reg;
    logic [1:0]         shift_type_reg;
    logic [SHAMT_W-1:0] shift_imm_reg;
    logic [DATA_W-1:0]  a_reg, b_reg, result_reg, pc_reg;
    logic [7:0]         rs_amt_reg;
    logic [3:0]         flags_reg, flags_pend_reg;

    logic [DATA_W-1:0]  rf_word [NREGS];
    logic               wr_en;

    // Compare opcodes (TST/TEQ/CMP/CMN, 8..11) never write back.
    assign wr_en = (state_reg == WRITE) && (op_reg[3:2] != 2'b10);

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_rf
            logic [DATA_W-1:0] word_reg;
            always_ff @(posedge Clk) begin
                if (RESET)
                    word_reg <= '0;
                else if (wr_en && rd_reg == ADDR_W'(gi))
                    word_reg <= result_reg;
            end
            assign rf_word[gi] = word_reg;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_valid) state_next = READ;
            READ:    state_next = EXEC;
            EXEC:    state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Barrel shifter; the extra bit in each extended vector carries the shifter C out.
    logic [7:0]         sh_amt;
    logic [SHAMT_W-1:0] sh_lo;
    logic               amt_eq_w, amt_gt_w;
    logic [DATA_W:0]    lsl_ext, lsr_ext, asr_ext;
    logic [DATA_W-1:0]  ror_val, sh_out;
    logic               sh_c;

    assign sh_amt   = shift_by_reg_reg ? rs_amt_reg : 8'(shift_imm_reg);
    assign sh_lo    = SHAMT_W'(sh_amt);
    assign amt_eq_w = 32'(sh_amt) == 32'(DATA_W);
    assign amt_gt_w = 32'(sh_amt) > 32'(DATA_W);
    assign lsl_ext  = {1'b0, b_reg} << sh_lo;
    assign lsr_ext  = {b_reg, 1'b0} >> sh_lo;
    assign asr_ext  = $signed({b_reg, 1'b0}) >>> sh_lo;
    assign ror_val  = (b_reg >> sh_lo) | (b_reg << (DATA_W_L - {1'b0, sh_lo}));

    always_comb begin
        sh_out = b_reg;
        sh_c   = flags_reg[1];
        if (sh_amt != 8'd0) begin
            case (shift_type)
                default: ;
            endcase
            case (shift_type_reg)
                2'd0: begin
                    if (amt_gt_w)      begin sh_out = '0; sh_c = 1'b0; end
                    else if (amt_eq_w) begin sh_out = '0; sh_c = b_reg[0]; end
                    else               begin sh_out = lsl_ext[DATA_W-1:0]; sh_c = lsl_ext[DATA_W]; end
                end
                2'd1: begin
                    if (amt_gt_w)      begin sh_out = '0; sh_c = 1'b0; end
                    else if (amt_eq_w) begin sh_out = '0; sh_c = b_reg[DATA_W-1]; end
                    else               begin sh_out = lsr_ext[DATA_W:1]; sh_c = lsr_ext[0]; end
                end
                2'd2: begin
                    if (amt_gt_w || amt_eq_w) begin
                        sh_out = {DATA_W{b_reg[DATA_W-1]}};
                        sh_c   = b_reg[DATA_W-1];
                    end else begin
                        sh_out = asr_ext[DATA_W:1];
                        sh_c   = asr_ext[0];
                    end
                end
                default: begin
                    sh_out = ror_val;
                    sh_c   = ror_val[DATA_W-1];
                end
            endcase
        end
    end

    // ALU: subtracts are x + ~y + cin so the adder carry is already NOT borrow.
    logic [DATA_W-1:0] add_x, add_y, logic_res, alu_res;
    logic              add_cin, is_arith, add_ovf;
    logic [DATA_W:0]   sum;
    logic [3:0]        alu_flags;

    always_comb begin
        add_x     = a_reg;
        add_y     = sh_out;
        add_cin   = 1'b0;
        is_arith  = 1'b1;
        logic_res = '0;
        case (op_reg)
            OP_SUB, OP_CMP: begin add_y = ~sh_out; add_cin = 1'b1; end
            OP_RSB:         begin add_x = sh_out; add_y = ~a_reg; add_cin = 1'b1; end
            OP_ADD, OP_CMN: begin add_cin = 1'b0; end
            OP_ADC:         begin add_cin = flags_reg[1]; end
            OP_SBC:         begin add_y = ~sh_out; add_cin = flags_reg[1]; end
            OP_RSC:         begin add_x = sh_out; add_y = ~a_reg; add_cin = flags_reg[1]; end
            default:        is_arith = 1'b0;
        endcase
        case (op_reg)
            OP_AND, OP_TST: logic_res = a_reg & sh_out;
            OP_EOR, OP_TEQ: logic_res = a_reg ^ sh_out;
            OP_ORR:         logic_res = a_reg | sh_out;
            OP_MOV:         logic_res = sh_out;
            OP_BIC:         logic_res = a_reg & ~sh_out;
            OP_MVN:         logic_res = ~sh_out;
            default:        logic_res = '0;
        endcase
    end

    assign sum       = {1'b0, add_x} + {1'b0, add_y} + {{DATA_W{1'b0}}, add_cin};
    assign add_ovf   = (add_x[DATA_W-1] == add_y[DATA_W-1]) && (sum[DATA_W-1] != add_x[DATA_W-1]);
    assign alu_res   = is_arith ? sum[DATA_W-1:0] : logic_res;
    assign alu_flags = {alu_res[DATA_W-1], alu_res == '0,
                        is_arith ? sum[DATA_W] : sh_c,
                        is_arith ? add_ovf : flags_reg[0]};

    always_ff @(posedge Clk) begin
        if (RESET) begin
            state_reg        <= IDLE;
            op_reg           <= '0;
            s_bit_reg        <= 1'b0;
            rn_reg           <= '0;
            rm_reg           <= '0;
            rs_reg           <= '0;
            rd_reg           <= '0;
            shift_type_reg   <= '0;
            shift_by_reg_reg <= 1'b0;
            shift_imm_reg    <= '0;
            a_reg            <= '0;
            b_reg            <= '0;
            rs_amt_reg       <= '0;
            result_reg       <= '0;
            flags_pend_reg   <= '0;
            flags_reg        <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && req_valid) begin
                op_reg           <= op;
                s_bit_reg        <= s_bit;
                rn_reg           <= rn;
                rm_reg           <= rm;
                rs_reg           <= rs;
                rd_reg           <= rd;
                shift_type_reg   <= shift_type;
                shift_by_reg_reg <= shift_by_reg;
                shift_imm_reg    <= shift_imm;
            end
            if (state_reg == READ) begin
                a_reg      <= rf_word[rn_reg];
                b_reg      <= rf_word[rm_reg];
                rs_amt_reg <= rf_word[rs_reg][7:0];
            end
            if (state_reg == EXEC) begin
                result_reg     <= alu_res;
                flags_pend_reg <= alu_flags;
            end
            if (state_reg == WRITE && s_bit_reg)
                flags_reg <= flags_pend_reg;
        end
    end

    always_ff @(posedge Clk) begin
        if (RESET)
            pc_reg <= '0;
        else if (pc_load)
            pc_reg <= pc_in;
        else if (pc_inc)
            pc_reg <= pc_reg + DATA_W'(PC_STEP);
    end

    assign req_ready = (state_reg == IDLE);
    assign done      = (state_reg == WRITE);
    assign result    = result_reg;
    assign flags     = flags_reg;
    assign pc_out    = pc_reg;
    assign dbg_rdata = rf_word[dbg_rsel];

endmodule

// File: tb/tb_param_exec_datapath.sv
// Scoreboard bench for param_exec_datapath: a bit-serial shifter and 64-bit ALU model
// predict each result/flags/rd value, queued at issue and compared at done.
module tb_param_exec_datapath;

    localparam logic [3:0] OP_AND = 4'd0,  OP_EOR = 4'd1,  OP_SUB = 4'd2,  OP_RSB = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4,  OP_ADC = 4'd5,  OP_SBC = 4'd6,  OP_RSC = 4'd7;
    localparam logic [3:0] OP_TST = 4'd8,  OP_TEQ = 4'd9,  OP_CMP = 4'd10, OP_CMN = 4'd11;
    localparam logic [3:0] OP_ORR = 4'd12, OP_MOV = 4'd13, OP_BIC = 4'd14, OP_MVN = 4'd15;

    logic        Clk, RESET, req_valid, req_ready, s_bit, shift_by_reg;
    logic [3:0]  op, rn, rm, rs, rd, dbg_rsel, flags;
    logic [1:0]  shift_type;
    logic [4:0]  shift_imm;
    logic        pc_load, pc_inc, done;
    logic [31:0] pc_in, result, pc_out, dbg_rdata;

    param_exec_datapath dut (
        .Clk(Clk), .RESET(RESET), .req_valid(req_valid), .req_ready(req_ready),
        .op(op), .s_bit(s_bit), .rn(rn), .rm(rm), .rs(rs), .rd(rd),
        .shift_type(shift_type), .shift_by_reg(shift_by_reg), .shift_imm(shift_imm),
        .pc_load(pc_load), .pc_in(pc_in), .pc_inc(pc_inc), .result(result),
        .flags(flags), .done(done), .pc_out(pc_out), .dbg_rsel(dbg_rsel), .dbg_rdata(dbg_rdata)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  flg;
        logic [3:0]  rd;
        logic [31:0] rd_val;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_regs [16];
    logic [3:0]  m_flags;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%08h want=%08h", tag, got, want);
        end
    endtask

    function automatic void m_shift(input logic [31:0] b, input int n, input logic [1:0] t,
                                    input logic cin, output logic [31:0] o, output logic c);
        o = b;
        c = cin;
        if (n == 0) return;
        case (t)
            2'd0: for (int i = 0; i < n; i++) begin c = o[31]; o = {o[30:0], 1'b0}; end
            2'd1: for (int i = 0; i < n; i++) begin c = o[0]; o = {1'b0, o[31:1]}; end
            2'd2: for (int i = 0; i < n; i++) begin c = o[0]; o = {o[31], o[31:1]}; end
            default: begin
                if (n % 32 == 0) c = o[31];
                else for (int i = 0; i < n % 32; i++) begin c = o[0]; o = {o[0], o[31:1]}; end
            end
        endcase
    endfunction

    function automatic void m_add(input logic [31:0] x, input logic [31:0] y, input int cin,
                                  output logic [31:0] r, output logic c, output logic v);
        longint ux, uy, sx, sy, t, st;
        ux = {32'd0, x}; uy = {32'd0, y};
        sx = $signed(x); sy = $signed(y);
        t  = ux + uy + cin;
        st = sx + sy + cin;
        r  = t[31:0];
        c  = t[32];
        v  = (st > 64'sd2147483647) || (st < -64'sd2147483648);
    endfunction

    function automatic void m_sub(input logic [31:0] x, input logic [31:0] y, input int bin,
                                  output logic [31:0] r, output logic c, output logic v);
        longint ux, uy, sx, sy, t, st;
        ux = {32'd0, x}; uy = {32'd0, y};
        sx = $signed(x); sy = $signed(y);
        t  = ux - uy - bin;
        st = sx - sy - bin;
        r  = t[31:0];
        c  = (ux >= uy + bin);
        v  = (st > 64'sd2147483647) || (st < -64'sd2147483648);
    endfunction

    function automatic void m_exec(input logic [3:0] op_i, input logic s_i, input logic [3:0] rd_i,
                                   input logic [3:0] rn_i, input logic [3:0] rm_i, input logic [3:0] rs_i,
                                   input logic [1:0] t_i, input logic sbr_i, input logic [4:0] imm_i,
                                   output exp_t e);
        logic [31:0] a, s, r;
        logic        shc, c, v;
        int          n;
        a = m_regs[rn_i];
        n = sbr_i ? int'(m_regs[rs_i][7:0]) : int'(imm_i);
        m_shift(m_regs[rm_i], n, t_i, m_flags[1], s, shc);
        c = shc;
        v = m_flags[0];
        r = 32'd0;
        case (op_i)
            OP_AND, OP_TST: r = a & s;
            OP_EOR, OP_TEQ: r = a ^ s;
            OP_SUB, OP_CMP: m_sub(a, s, 0, r, c, v);
            OP_RSB:         m_sub(s, a, 0, r, c, v);
            OP_ADD, OP_CMN: m_add(a, s, 0, r, c, v);
            OP_ADC:         m_add(a, s, int'(m_flags[1]), r, c, v);
            OP_SBC:         m_sub(a, s, int'(!m_flags[1]), r, c, v);
            OP_RSC:         m_sub(s, a, int'(!m_flags[1]), r, c, v);
            OP_ORR:         r = a | s;
            OP_MOV:         r = s;
            OP_BIC:         r = a & ~s;
            default:        r = ~s;
        endcase
        if (s_i) m_flags = {r[31], r == 32'd0, c, v};
        if (!(op_i inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN})) m_regs[rd_i] = r;
        e.res    = r;
        e.flg    = m_flags;
        e.rd     = rd_i;
        e.rd_val = m_regs[rd_i];
    endfunction

    task automatic do_op(input logic [3:0] op_i, input logic s_i, input logic [3:0] rd_i,
                         input logic [3:0] rn_i, input logic [3:0] rm_i, input logic [3:0] rs_i,
                         input logic [1:0] t_i, input logic sbr_i, input logic [4:0] imm_i,
                         input bit junk);
        exp_t e, g;
        int   lat;
        m_exec(op_i, s_i, rd_i, rn_i, rm_i, rs_i, t_i, sbr_i, imm_i, e);
        sb_q.push_back(e);
        @(negedge Clk);
        check("ready_before", req_ready, 1'b1);
        op = op_i; s_bit = s_i; rd = rd_i; rn = rn_i; rm = rm_i; rs = rs_i;
        shift_type = t_i; shift_by_reg = sbr_i; shift_imm = imm_i;
        req_valid = 1'b1;
        @(posedge Clk); #1;
        if (junk) begin
            // a second request while busy must be dropped, and the live fields ignored
            op = OP_MVN; rd = 4'd7; rm = 4'd0; s_bit = 1'b1; shift_by_reg = 1'b0; shift_imm = 5'd0;
        end else begin
            req_valid = 1'b0;
        end
        lat = 1;
        while (!done && lat < 8) begin
            @(posedge Clk); #1;
            lat++;
        end
        req_valid = 1'b0;
        check("done", done, 1'b1);
        check("latency", lat, 3);
        g = sb_q.pop_front();
        check("result", result, g.res);
        @(posedge Clk); #1;
        check("flags", flags, g.flg);
        dbg_rsel = g.rd;
        #1;
        check("rd_value", dbg_rdata, g.rd_val);
        check("ready_after", req_ready, 1'b1);
        if (junk) begin
            dbg_rsel = 4'd7;
            #1;
            check("busy_req_dropped", dbg_rdata, m_regs[7]);
        end
        $display("op=%0d rd=%0d result=%08h flags=%04b", op_i, rd_i, result, flags);
    endtask

    logic [31:0] sh_res_tab [9];
    logic        sh_c_tab   [9];
    logic [3:0]  sh_rs_tab  [3];

    initial begin
        RESET = 1'b1; req_valid = 1'b0; op = '0; s_bit = 1'b0; rn = '0; rm = '0; rs = '0; rd = '0;
        shift_type = '0; shift_by_reg = 1'b0; shift_imm = '0; pc_load = 1'b0; pc_in = '0;
        pc_inc = 1'b0; dbg_rsel = '0;
        for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
        m_flags = 4'd0;
        repeat (2) @(posedge Clk);
        #1 RESET = 1'b0;
        for (int i = 0; i < 16; i++) begin
            dbg_rsel = 4'(i);
            #1 check("reset_reg", dbg_rdata, 32'd0);
        end
        check("reset_flags", flags, 4'd0);
        check("reset_pc", pc_out, 32'd0);
        check("reset_ready", req_ready, 1'b1);
        check("reset_done", done, 1'b0);
        check("reset_result", result, 32'd0);

        // build constants from an all-zero register file
        do_op(OP_MVN, 0, 4'd3, 4'd0, 4'd0, 4'd0, 2'd0, 0, 5'd0, 0);   // R3 = FFFFFFFF
        do_op(OP_MOV, 0, 4'd4, 4'd0, 4'd3, 4'd0, 2'd1, 0, 5'd31, 0);  // R4 = 1
        do_op(OP_ADD, 0, 4'd5, 4'd4, 4'd4, 4'd0, 2'd0, 0, 5'd2, 0);   // R5 = 5
        do_op(OP_MOV, 0, 4'd1, 4'd0, 4'd5, 4'd0, 2'd0, 0, 5'd0, 0);   // R1 = 5
        do_op(OP_ADD, 0, 4'd2, 4'd1, 4'd1, 4'd0, 2'd0, 0, 5'd0, 1);   // R2 = 10
        dbg_rsel = 4'd2;
        #1 check("add_5_5", dbg_rdata, 32'd10);
        do_op(OP_SUB, 0, 4'd6, 4'd5, 4'd4, 4'd0, 2'd0, 0, 5'd1, 0);   // R6 = 3
        do_op(OP_CMP, 1, 4'd9, 4'd6, 4'd5, 4'd0, 2'd0, 0, 5'd0, 0);   // CMP 3,5
        check("cmp_flags", flags, 4'b1000);
        dbg_rsel = 4'd9;
        #1 check("cmp_no_write", dbg_rdata, 32'd0);
        do_op(OP_MOV, 0, 4'd7, 4'd0, 4'd3, 4'd0, 2'd1, 0, 5'd1, 0);   // R7 = 7FFFFFFF
        do_op(OP_ADD, 1, 4'd8, 4'd7, 4'd4, 4'd0, 2'd0, 0, 5'd0, 0);
        check("ovf_result", result, 32'h8000_0000);
        check("ovf_flags", flags, 4'b1001);
        do_op(OP_ADD, 1, 4'd8, 4'd3, 4'd4, 4'd0, 2'd0, 0, 5'd0, 0);
        check("wrap_result", result, 32'd0);
        check("wrap_flags", flags, 4'b0110);
        do_op(OP_MOV, 0, 4'd10, 4'd0, 4'd4, 4'd0, 2'd3, 0, 5'd1, 0);  // R10 = 80000000
        do_op(OP_ADD, 0, 4'd10, 4'd10, 4'd4, 4'd0, 2'd0, 0, 5'd0, 0); // R10 = 80000001
        do_op(OP_MOV, 0, 4'd11, 4'd0, 4'd4, 4'd0, 2'd0, 0, 5'd5, 0);  // R11 = 32
        do_op(OP_ADD, 0, 4'd12, 4'd11, 4'd4, 4'd0, 2'd0, 0, 5'd0, 0); // R12 = 33

        // shift-by-register boundaries on 0x80000001: Rs = 32, 33, 0 (R13)
        sh_rs_tab = '{4'd11, 4'd12, 4'd13};
        sh_res_tab = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF,
                       32'h8000_0001, 32'h8000_0001, 32'h8000_0001};
        sh_c_tab = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            for (int t = 0; t < 3; t++) begin
                do_op(OP_MOV, 1, 4'd14, 4'd0, 4'd10, sh_rs_tab[i], 2'(t), 1, 5'd0, 0);
                check("shift_result", result, sh_res_tab[i*3+t]);
                check("shift_carry", flags[1], sh_c_tab[i*3+t]);
            end
        end

        for (int i = 0; i < 30; i++) begin
            do_op(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 0);
        end

        // PC: increment, simultaneous load+inc, wrap, plain load
        @(negedge Clk); pc_inc = 1'b1;
        repeat (3) @(posedge Clk);
        #1 pc_inc = 1'b0;
        check("pc_inc3", pc_out, 32'd12);
        @(negedge Clk); pc_load = 1'b1; pc_inc = 1'b1; pc_in = 32'hFFFF_FFFC;
        @(posedge Clk); #1 pc_load = 1'b0; pc_inc = 1'b0;
        check("pc_load_prio", pc_out, 32'hFFFF_FFFC);
        @(negedge Clk); pc_inc = 1'b1;
        @(posedge Clk); #1 pc_inc = 1'b0;
        check("pc_wrap", pc_out, 32'd0);
        @(negedge Clk); pc_load = 1'b1; pc_in = 32'h0000_1234;
        @(posedge Clk); #1 pc_load = 1'b0;
        check("pc_load", pc_out, 32'h0000_1234);
        $display("pc checks done pc=%08h", pc_out);

        // reset while in EXEC: no write, no flag commit, no done pulse
        @(negedge Clk);
        op = OP_MVN; s_bit = 1'b1; rd = 4'd15; rm = 4'd0; shift_by_reg = 1'b0; shift_imm = 5'd0;
        req_valid = 1'b1;
        @(posedge Clk); #1 req_valid = 1'b0;
        @(posedge Clk); #1 RESET = 1'b1;
        @(posedge Clk); #1 RESET = 1'b0;
        check("abort_done", done, 1'b0);
        check("abort_ready", req_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk); #1 check("abort_no_done", done, 1'b0);
        end
        dbg_rsel = 4'd15;
        #1 check("abort_rd", dbg_rdata, 32'd0);
        check("abort_flags", flags, 4'd0);
        for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
        m_flags = 4'd0;
        $display("reset-in-EXEC abort rd15=%08h flags=%04b", dbg_rdata, flags);
        do_op(OP_MVN, 1, 4'd1, 4'd0, 4'd0, 4'd0, 2'd0, 0, 5'd0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
